pe_conv_ctrl: RTL and testbench

- Parametrised successor PE controller for the row-stationary conv array.
- Sequences weight load, raster IFM streaming, MAC pipeline drain and output handshaking across a runtime-configured number of input channels and kernels.
- Adds abort and downstream backpressure (valid/ready), and emits partial-sum writes on non-final channels.
- Sits between the global buffer scheduler (start/cfg) and the PE datapath (read/set strobes).

---
 rtl/pe_conv_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pe_conv_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_ctrl.sv
// Row-stationary PE controller. For each channel and kernel it loads weights, rasters the IFM,
// drains the MAC pipe, and hands outputs downstream with valid/ready backpressure.
module pe_conv_ctrl #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IFM_WIDTH   = 64,
  parameter int unsigned IFM_HEIGHT  = 64,
  parameter int unsigned MAX_CHANNEL = 16,
  parameter int unsigned MAX_KERNEL  = 16,
  parameter int unsigned PIPE_LAT    = 2
) (
  input  logic                              clk1,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [$clog2(MAX_CHANNEL+1)-1:0]  cfg_channels,
  input  logic [$clog2(MAX_KERNEL+1)-1:0]   cfg_kernels,
  input  logic                              ofm_ready,
  output logic                              wgt_read,
  output logic                              set_wgt,
  output logic                              ifm_read,
  output logic                              set_ifm,
  output logic                              acc_clear,
  output logic                              psum_wr,
  output logic                              p_valid_output,
  output logic                              last_channel,
  output logic [$clog2(IFM_WIDTH)-1:0]      cnt_col,
  output logic [$clog2(IFM_HEIGHT)-1:0]     cnt_row,
  output logic [$clog2(MAX_CHANNEL)-1:0]    cnt_channel,
  output logic [$clog2(MAX_KERNEL)-1:0]     cnt_kernel,
  output logic                              busy,
  output logic                              end_conv,
  output logic [2:0]                        state
);

  localparam int unsigned CfgChW = $clog2(MAX_CHANNEL + 1);
  localparam int unsigned CfgKW  = $clog2(MAX_KERNEL + 1);
  localparam int unsigned ColW   = $clog2(IFM_WIDTH);
  localparam int unsigned RowW   = $clog2(IFM_HEIGHT);
  localparam int unsigned ChW    = $clog2(MAX_CHANNEL);
  localparam int unsigned KW     = $clog2(MAX_KERNEL);
  localparam int unsigned WgtW   = $clog2(KERNEL_SIZE * KERNEL_SIZE + 1);
  localparam int unsigned DrnW   = $clog2(PIPE_LAT + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoadWgt = 3'd1;
  localparam logic [2:0] StCompute = 3'd2;
  localparam logic [2:0] StDrain   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WgtW-1:0]   wgt_q, wgt_d;
  logic [DrnW-1:0]   drn_q, drn_d;
  logic [CfgChW-1:0] ch_cfg_q, ch_cfg_d, ch_sel;
  logic [CfgKW-1:0]  k_cfg_q, k_cfg_d, k_sel;
  logic              p_valid_q, p_valid_d;
  logic              psum_wr_q, psum_wr_d;
  logic              stall, consume, win, last_ch;

  // Zero means one; anything past the array limit is clamped to it.
  always_comb begin
    if (cfg_channels == '0)                   ch_sel = CfgChW'(1);
    else if (32'(cfg_channels) > MAX_CHANNEL) ch_sel = CfgChW'(MAX_CHANNEL);
    else                                      ch_sel = cfg_channels;
    if (cfg_kernels == '0)                    k_sel = CfgKW'(1);
    else if (32'(cfg_kernels) > MAX_KERNEL)   k_sel = CfgKW'(MAX_KERNEL);
    else                                      k_sel = cfg_kernels;
  end

  assign last_ch = (32'(ch_q) + 32'd1 == 32'(ch_cfg_q));
  assign stall   = p_valid_q & ~ofm_ready;
  assign consume = (state_q == StCompute) & ~stall;
  assign win     = consume & (32'(row_q) >= KERNEL_SIZE - 1) & (32'(col_q) >= KERNEL_SIZE - 1);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    ch_d      = ch_q;
    k_d       = k_q;
    wgt_d     = wgt_q;
    drn_d     = drn_q;
    ch_cfg_d  = ch_cfg_q;
    k_cfg_d   = k_cfg_q;
    psum_wr_d = win & ~last_ch;
    p_valid_d = p_valid_q;
    // A fresh last-channel window overrides the clear from a completing handshake.
    if (p_valid_q && ofm_ready) p_valid_d = 1'b0;
    if (win && last_ch)         p_valid_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StLoadWgt;
          ch_cfg_d = ch_sel;
          k_cfg_d  = k_sel;
        end
      end
      StLoadWgt: begin
        if (32'(wgt_q) == KERNEL_SIZE * KERNEL_SIZE - 1) begin
          wgt_d   = '0;
          state_d = StCompute;
        end else begin
          wgt_d = wgt_q + WgtW'(1);
        end
      end
      StCompute: begin
        if (consume) begin
          if (32'(col_q) == IFM_WIDTH - 1) begin
            col_d = '0;
            if (32'(row_q) == IFM_HEIGHT - 1) begin
              row_d   = '0;
              drn_d   = '0;
              state_d = StDrain;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StDrain: begin
        if (!stall) begin
          if (32'(drn_q) == PIPE_LAT - 1) begin
            drn_d = '0;
            if (!last_ch) begin
              ch_d    = ch_q + ChW'(1);
              state_d = StLoadWgt;
            end else if (32'(k_q) + 32'd1 < 32'(k_cfg_q)) begin
              k_d     = k_q + KW'(1);
              ch_d    = '0;
              state_d = StLoadWgt;
            end else begin
              state_d = StDone;
            end
          end else begin
            drn_d = drn_q + DrnW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      p_valid_d = 1'b0;
      psum_wr_d = 1'b0;
    end
    if (state_d == StIdle) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
      k_d   = '0;
      wgt_d = '0;
      drn_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      k_q       <= '0;
      wgt_q     <= '0;
      drn_q     <= '0;
      ch_cfg_q  <= CfgChW'(1);
      k_cfg_q   <= CfgKW'(1);
      p_valid_q <= 1'b0;
      psum_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      k_q       <= k_d;
      wgt_q     <= wgt_d;
      drn_q     <= drn_d;
      ch_cfg_q  <= ch_cfg_d;
      k_cfg_q   <= k_cfg_d;
      p_valid_q <= p_valid_d;
      psum_wr_q <= psum_wr_d;
    end
  end

  assign wgt_read       = (state_q == StLoadWgt);
  assign set_wgt        = (state_q == StLoadWgt);
  assign ifm_read       = consume;
  assign set_ifm        = consume;
  assign acc_clear      = (state_q == StCompute) & (ch_q == '0) & (row_q == '0) & (col_q == '0);
  assign psum_wr        = psum_wr_q;
  assign p_valid_output = p_valid_q;
  assign last_channel   = last_ch & ((state_q == StLoadWgt) | (state_q == StCompute) |
                                     (state_q == StDrain));
  assign cnt_col        = col_q;
  assign cnt_row        = row_q;
  assign cnt_channel    = ch_q;
  assign cnt_kernel     = k_q;
  assign busy           = (state_q != StIdle);
  assign end_conv       = (state_q == StDone);
  assign state          = state_q;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
// Directed bench for pe_conv_ctrl on a 4x4 IFM with a 3x3 kernel: per-job counts against a
// hand-computed table, a state timeline for the two-channel job, plus reset and abort cases.
module tb_pe_conv_ctrl;
  localparam int unsigned K = 3, W = 4, H = 4, MC = 16, MK = 16, PL = 2;
  localparam int unsigned CfgChW = $clog2(MC + 1);
  localparam int unsigned CfgKW  = $clog2(MK + 1);

  typedef struct {
    int ch; int k; int sf; int sl; int sp;
    int e_end; int e_psum; int e_hs; int e_acc; int e_nl; int e_mk; int e_stall; int e_ifm;
    int e_wgt;
  } vec_t;
  typedef struct { int cyc; int st; int ch; int lc; } cp_t;

  logic clk1 = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ofm_ready = 1'b1;
  logic [CfgChW-1:0] cfg_channels = '0;
  logic [CfgKW-1:0]  cfg_kernels  = '0;
  logic wgt_read, set_wgt, ifm_read, set_ifm, acc_clear, psum_wr, p_valid_output, last_channel;
  logic [$clog2(W)-1:0]  cnt_col;
  logic [$clog2(H)-1:0]  cnt_row;
  logic [$clog2(MC)-1:0] cnt_channel;
  logic [$clog2(MK)-1:0] cnt_kernel;
  logic busy, end_conv;
  logic [2:0] state;

  pe_conv_ctrl #(
    .KERNEL_SIZE(K), .IFM_WIDTH(W), .IFM_HEIGHT(H), .MAX_CHANNEL(MC), .MAX_KERNEL(MK),
    .PIPE_LAT(PL)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort), .cfg_channels(cfg_channels),
    .cfg_kernels(cfg_kernels), .ofm_ready(ofm_ready), .wgt_read(wgt_read), .set_wgt(set_wgt),
    .ifm_read(ifm_read), .set_ifm(set_ifm), .acc_clear(acc_clear), .psum_wr(psum_wr),
    .p_valid_output(p_valid_output), .last_channel(last_channel), .cnt_col(cnt_col),
    .cnt_row(cnt_row), .cnt_channel(cnt_channel), .cnt_kernel(cnt_kernel), .busy(busy),
    .end_conv(end_conv), .state(state)
  );

  always #5 clk1 = ~clk1;

  int n_vec = 0, n_err = 0;
  int cyc;
  int end_cyc, end_cnt, idle_cyc, psum_cnt, hs_cnt, acc_cnt, nl_cnt, max_k, stall_cnt;
  int ifm_cnt, wgt_cnt, hold_err;
  int st_log [0:599];
  int ch_log [0:599];
  int lc_log [0:599];
  vec_t vecs [8];
  cp_t  cps [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic begin_job(input int ch, input int k);
    cfg_channels = CfgChW'(ch);
    cfg_kernels  = CfgKW'(k);
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_job(input vec_t v);
    bit done, prev_stall;
    int prev_col, prev_row;
    end_cyc = -1; end_cnt = 0; idle_cyc = -1; psum_cnt = 0; hs_cnt = 0; acc_cnt = 0;
    nl_cnt = 0; max_k = 0; stall_cnt = 0; ifm_cnt = 0; wgt_cnt = 0; hold_err = 0;
    prev_stall = 0; prev_col = 0; prev_row = 0; done = 0;
    begin_job(v.ch, v.k);
    while (!done && cyc < 600) begin
      ofm_ready = !(cyc >= v.sf && cyc < v.sf + v.sl);
      start = (cyc == v.sp);
      if (cyc == v.sp) begin
        cfg_channels = CfgChW'(1);
        cfg_kernels  = CfgKW'(3);
      end
      @(negedge clk1);
      st_log[cyc] = int'(state);
      ch_log[cyc] = int'(cnt_channel);
      lc_log[cyc] = int'(last_channel);
      if (end_conv) begin
        if (end_cnt == 0) end_cyc = cyc;
        end_cnt++;
      end
      if (psum_wr) psum_cnt++;
      if (p_valid_output && ofm_ready) hs_cnt++;
      if (acc_clear) acc_cnt++;
      if (wgt_read && set_wgt) wgt_cnt++;
      if (state == 3'd2 && ifm_read && set_ifm) ifm_cnt++;
      if (state == 3'd2 && !ifm_read && !set_ifm) stall_cnt++;
      if (state inside {3'd1, 3'd2, 3'd3} && !last_channel) nl_cnt++;
      if (int'(cnt_kernel) > max_k) max_k = int'(cnt_kernel);
      if (prev_stall && (int'(cnt_col) != prev_col || int'(cnt_row) != prev_row ||
                         !p_valid_output)) hold_err++;
      prev_stall = (state == 3'd2) && p_valid_output && !ofm_ready;
      prev_col = int'(cnt_col);
      prev_row = int'(cnt_row);
      if (!busy) begin
        idle_cyc = cyc;
        done = 1;
      end else begin
        @(posedge clk1); #1;
        cyc++;
      end
    end
    start = 1'b0;
    ofm_ready = 1'b1;
  endtask

  task automatic check_job(input vec_t v, input string tag);
    check({tag, " end_cyc"}, end_cyc, v.e_end);
    check({tag, " end_pulses"}, end_cnt, 1);
    check({tag, " idle_cyc"}, idle_cyc, v.e_end + 1);
    check({tag, " psum_wr"}, psum_cnt, v.e_psum);
    check({tag, " handshakes"}, hs_cnt, v.e_hs);
    check({tag, " acc_clear"}, acc_cnt, v.e_acc);
    check({tag, " not_last"}, nl_cnt, v.e_nl);
    check({tag, " max_kernel"}, max_k, v.e_mk);
    check({tag, " stall_cyc"}, stall_cnt, v.e_stall);
    check({tag, " hold_err"}, hold_err, 0);
    check({tag, " ifm_reads"}, ifm_cnt, v.e_ifm);
    check({tag, " wgt_reads"}, wgt_cnt, v.e_wgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ch  k  sf  sl  sp  end psum hs acc  nl  mk st ifm wgt
    vecs[0] = '{  2, 1,  0, 0,  0,  55,  4,  4,  1,  27,  0, 0,  32,  18};
    vecs[1] = '{  2, 1, 48, 5,  0,  60,  4,  4,  1,  27,  0, 5,  32,  18};
    vecs[2] = '{  1, 3,  0, 0,  0,  82,  0, 12,  3,   0,  2, 0,  48,  27};
    vecs[3] = '{  0, 1,  0, 0,  0,  28,  0,  4,  1,   0,  0, 0,  16,   9};
    vecs[4] = '{ 31, 1,  0, 0,  0, 433, 60,  4,  1, 405,  0, 0, 256, 144};
    vecs[5] = '{  1, 0,  0, 0,  0,  28,  0,  4,  1,   0,  0, 0,  16,   9};
    vecs[6] = '{  2, 1,  0, 0, 20,  55,  4,  4,  1,  27,  0, 0,  32,  18};
    vecs[7] = '{  1, 31, 0, 0,  0, 433,  0, 64, 16,   0, 15, 0, 256, 144};
    // Timeline of the unstalled two-channel job: {cycle, state, channel, last_channel}.
    cps[0]  = '{1, 1, 0, 0};   cps[1]  = '{9, 1, 0, 0};   cps[2]  = '{10, 2, 0, 0};
    cps[3]  = '{25, 2, 0, 0};  cps[4]  = '{26, 3, 0, 0};  cps[5]  = '{27, 3, 0, 0};
    cps[6]  = '{28, 1, 1, 1};  cps[7]  = '{36, 1, 1, 1};  cps[8]  = '{37, 2, 1, 1};
    cps[9]  = '{53, 3, 1, 1};  cps[10] = '{54, 3, 1, 1};  cps[11] = '{55, 4, 1, 0};
    cps[12] = '{56, 0, 0, 0};

    repeat (2) @(negedge clk1);
    check("rst state", state, 0);
    check("rst outputs", {wgt_read, set_wgt, ifm_read, set_ifm, acc_clear, psum_wr,
                          p_valid_output, last_channel, busy, end_conv}, 0);
    rst_n = 1'b1;
    @(negedge clk1);
    check("idle after rst", {state, cnt_col, cnt_row, cnt_channel, cnt_kernel}, 0);

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i]);
      check_job(vecs[i], $sformatf("v%0d", i));
      if (i == 0) begin
        for (int j = 0; j < 13; j++) begin
          check($sformatf("tl c%0d state", cps[j].cyc), st_log[cps[j].cyc], cps[j].st);
          check($sformatf("tl c%0d chan", cps[j].cyc), ch_log[cps[j].cyc], cps[j].ch);
          check($sformatf("tl c%0d last", cps[j].cyc), lc_log[cps[j].cyc], cps[j].lc);
        end
      end
    end

    // Asynchronous reset in the middle of channel 0 COMPUTE.
    @(negedge clk1);
    begin_job(2, 1);
    repeat (14) begin @(posedge clk1); #1; cyc++; end
    @(negedge clk1);
    check("rst_mid pre col", cnt_col, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid state", state, 0);
    check("rst_mid outputs", {wgt_read, set_wgt, ifm_read, set_ifm, acc_clear, psum_wr,
                              p_valid_output, last_channel, busy, end_conv}, 0);
    check("rst_mid counters", {cnt_col, cnt_row, cnt_channel, cnt_kernel}, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    check("rst_mid stays idle", state, 0);

    // Abort while channel 1 has a pending output.
    begin_job(2, 1);
    repeat (47) begin @(posedge clk1); #1; cyc++; end
    @(negedge clk1);
    check("abort pre p_valid", p_valid_output, 1);
    check("abort pre channel", cnt_channel, 1);
    abort = 1'b1;
    @(posedge clk1); #1;
    abort = 1'b0;
    check("abort state", state, 0);
    check("abort p_valid", p_valid_output, 0);
    check("abort counters", {cnt_col, cnt_row, cnt_channel, cnt_kernel}, 0);
    check("abort end_conv", end_conv, 0);
    begin
      int quiet_err = 0;
      repeat (5) begin
        @(negedge clk1);
        if (end_conv || busy) quiet_err++;
      end
      check("abort quiet", quiet_err, 0);
    end
    abort = 1'b1;
    start = 1'b1;
    cfg_channels = CfgChW'(2);
    cfg_kernels  = CfgKW'(1);
    @(posedge clk1); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort+start state", state, 0);
    @(negedge clk1);
    check("abort+start busy", busy, 0);
    run_job(vecs[0]);
    check_job(vecs[0], "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
